// File: rtl/rs_kes_ribm_gf8_if.sv
// Handshake and data bundle for the RS(255,251) key-equation solver.
// The master drives the start request and syndromes. The slave returns Λ, Ω and the done pulse.
interface rs_kes_ribm_gf8_if;
  logic       kes_ena;
  logic [7:0] rs_syn0;
  logic [7:0] rs_syn1;
  logic [7:0] rs_syn2;
  logic [7:0] rs_syn3;
  logic [7:0] rs_lambda0;
  logic [7:0] rs_lambda1;
  logic [7:0] rs_lambda2;
  logic [7:0] rs_omega0;
  logic [7:0] rs_omega1;
  logic       kes_done;

  modport master (
    output kes_ena, rs_syn0, rs_syn1, rs_syn2, rs_syn3,
    input  rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1, kes_done
  );

  modport slave (
    input  kes_ena, rs_syn0, rs_syn1, rs_syn2, rs_syn3,
    output rs_lambda0, rs_lambda1, rs_lambda2, rs_omega0, rs_omega1, kes_done
  );
endinterface

// File: rtl/rs_kes_ribm_gf8.sv
// RiBM key-equation solver for RS(255,251), t = 2, over GF(2^8) mod 0x11D.
// Performs four inversionless iterations, one per clock, and returns Λ(x) and Ω(x).
module rs_kes_ribm_gf8 (
  input  logic              clk,
  input  logic              rstn,
  rs_kes_ribm_gf8_if.slave  kes_if
);

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_IT0  = 5'b00010,
    ST_IT1  = 5'b00100,
    ST_IT2  = 5'b01000,
    ST_IT3  = 5'b10000
  } state_e;

  // Shift-and-add GF(2^8) multiply, reducing by x^8 = x^4+x^3+x^2+1 on each shift.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      if (aa[7]) aa = {aa[6:0], 1'b0} ^ 8'h1D;
      else       aa = {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] delta_q [0:6];
  logic [7:0] theta_q [0:6];
  logic [7:0] gamma_q;
  logic [2:0] l_q;

  logic [7:0] delta_d [0:6];
  logic [1:0] k_d;
  logic [7:0] dlt_d;
  logic       swap_d;

  logic [7:0] lambda0_q, lambda1_q, lambda2_q;
  logic [7:0] omega0_q, omega1_q;
  logic       done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (kes_if.kes_ena) state_d = ST_IT0;
        else                state_d = ST_IDLE;
      end
      ST_IT0:  state_d = ST_IT1;
      ST_IT1:  state_d = ST_IT2;
      ST_IT2:  state_d = ST_IT3;
      ST_IT3:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One RiBM iteration: Δ' = γ·(Δ shifted down) ⊕ δ·Θ, plus the swap decision.
  always_comb begin
    case (state_q)
      ST_IT0:  k_d = 2'd0;
      ST_IT1:  k_d = 2'd1;
      ST_IT2:  k_d = 2'd2;
      ST_IT3:  k_d = 2'd3;
      default: k_d = 2'd0;
    endcase
    dlt_d = delta_q[0];
    for (int i = 0; i < 6; i++) begin
      delta_d[i] = gf_mul(gamma_q, delta_q[i+1]) ^ gf_mul(dlt_d, theta_q[i]);
    end
    delta_d[6] = gf_mul(dlt_d, theta_q[6]);
    swap_d = (dlt_d != 8'h00) && ({l_q, 1'b0} <= {2'b00, k_d});
  end

  always_ff @(posedge clk) begin
    if (rstn) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Iteration registers: loaded on the start edge, advanced in IT0..IT3, held otherwise.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 7; i++) begin
        delta_q[i] <= 8'h00;
        theta_q[i] <= 8'h00;
      end
      gamma_q <= 8'h00;
      l_q     <= 3'd0;
    end else if (state_q == ST_IDLE) begin
      if (kes_if.kes_ena) begin
        delta_q[0] <= kes_if.rs_syn0;
        delta_q[1] <= kes_if.rs_syn1;
        delta_q[2] <= kes_if.rs_syn2;
        delta_q[3] <= kes_if.rs_syn3;
        delta_q[4] <= 8'h00;
        delta_q[5] <= 8'h00;
        delta_q[6] <= 8'h01;
        theta_q[0] <= kes_if.rs_syn0;
        theta_q[1] <= kes_if.rs_syn1;
        theta_q[2] <= kes_if.rs_syn2;
        theta_q[3] <= kes_if.rs_syn3;
        theta_q[4] <= 8'h00;
        theta_q[5] <= 8'h00;
        theta_q[6] <= 8'h01;
        gamma_q    <= 8'h01;
        l_q        <= 3'd0;
      end
    end else begin
      for (int i = 0; i < 7; i++) delta_q[i] <= delta_d[i];
      if (swap_d) begin
        for (int i = 0; i < 6; i++) theta_q[i] <= delta_q[i+1];
        theta_q[6] <= 8'h00;
        gamma_q    <= dlt_d;
        l_q        <= {1'b0, k_d} + 3'd1 - l_q;
      end
    end
  end

  // Result registers capture the final iteration's next-state Δ on the IT3 edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      lambda0_q <= 8'h00;
      lambda1_q <= 8'h00;
      lambda2_q <= 8'h00;
      omega0_q  <= 8'h00;
      omega1_q  <= 8'h00;
      done_q    <= 1'b0;
    end else if (state_q == ST_IT3) begin
      lambda0_q <= delta_d[2];
      lambda1_q <= delta_d[3];
      lambda2_q <= delta_d[4];
      omega0_q  <= delta_d[0];
      omega1_q  <= delta_d[1];
      done_q    <= 1'b1;
    end else begin
      done_q    <= 1'b0;
    end
  end

  assign kes_if.rs_lambda0 = lambda0_q;
  assign kes_if.rs_lambda1 = lambda1_q;
  assign kes_if.rs_lambda2 = lambda2_q;
  assign kes_if.rs_omega0  = omega0_q;
  assign kes_if.rs_omega1  = omega1_q;
  assign kes_if.kes_done   = done_q;

endmodule

// File: tb/tb_rs_kes_ribm_gf8.sv
// Self-checking bench for rs_kes_ribm_gf8: log/antilog GF model plus a cycle-level timing model.
// Uses randomized and directed stimulus.
module tb_rs_kes_ribm_gf8;

  logic clk;
  logic rstn;
  rs_kes_ribm_gf8_if kif ();

  rs_kes_ribm_gf8 dut (
    .clk    (clk),
    .rstn   (rstn),
    .kes_if (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int gexp [0:254];
  int glog [0:255];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Packed result order: {λ0, λ1, λ2, ω0, ω1}
  function automatic logic [39:0] ribm(input logic [7:0] s0, input logic [7:0] s1,
                                       input logic [7:0] s2, input logic [7:0] s3);
    int d [7];
    int th [7];
    int nd [7];
    int gam, l, dl;
    d = '{int'(s0), int'(s1), int'(s2), int'(s3), 0, 0, 1};
    th = d;
    gam = 1;
    l = 0;
    for (int k = 0; k < 4; k++) begin
      dl = d[0];
      for (int i = 0; i < 7; i++)
        nd[i] = gmul(gam, (i < 6) ? d[i+1] : 0) ^ gmul(dl, th[i]);
      if (dl != 0 && 2 * l <= k) begin
        for (int i = 0; i < 6; i++) th[i] = d[i+1];
        th[6] = 0;
        gam = dl;
        l = k + 1 - l;
      end
      d = nd;
    end
    return {8'(d[2]), 8'(d[3]), 8'(d[4]), 8'(d[0]), 8'(d[1])};
  endfunction

  logic        m_busy;
  int          m_cnt;
  logic [39:0] m_pend;
  logic [39:0] m_out;
  logic        m_done;

  // Reference timing: start accepted only when idle, results 4 edges later.
  always @(posedge clk) begin
    if (rstn) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_out  <= 40'h0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (kif.kes_ena) begin
          m_busy <= 1'b1;
          m_cnt  <= 0;
          m_pend <= ribm(kif.rs_syn0, kif.rs_syn1, kif.rs_syn2, kif.rs_syn3);
        end
      end else if (m_cnt == 3) begin
        m_busy <= 1'b0;
        m_out  <= m_pend;
        m_done <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  int tests;
  int fails;
  int ndone;

  function automatic logic [39:0] dut_out();
    return {kif.rs_lambda0, kif.rs_lambda1, kif.rs_lambda2, kif.rs_omega0, kif.rs_omega1};
  endfunction

  task automatic check40(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic step();
    @(negedge clk);
    check1("done_vs_model", kif.kes_done, m_done);
    check40("out_vs_model", dut_out(), m_out);
    if (kif.kes_done === 1'b1) ndone++;
  endtask

  task automatic set_syn(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    kif.rs_syn0 = a;
    kif.rs_syn1 = b;
    kif.rs_syn2 = c;
    kif.rs_syn3 = d;
  endtask

  task automatic rand_syn();
    set_syn(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic run_lit(input string name, input logic [7:0] s, input logic [39:0] exp);
    kif.kes_ena = 1'b1;
    set_syn(s, s, s, s);
    step();
    kif.kes_ena = 1'b0;
    rand_syn();
    for (int i = 0; i < 3; i++) begin
      step();
      check1({name, "_early_done"}, kif.kes_done, 1'b0);
    end
    step();
    check1({name, "_done"}, kif.kes_done, 1'b1);
    check40({name, "_out"}, dut_out(), exp);
    step();
    check1({name, "_done_fall"}, kif.kes_done, 1'b0);
  endtask

  initial begin
    int x;
    tests = 0;
    fails = 0;
    ndone = 0;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    glog[0] = 0;

    rstn = 1'b1;
    kif.kes_ena = 1'b0;
    set_syn(8'h00, 8'h00, 8'h00, 8'h00);

    check40("model_s00", ribm(8'h00, 8'h00, 8'h00, 8'h00), 40'h01_00_00_00_00);
    check40("model_s01", ribm(8'h01, 8'h01, 8'h01, 8'h01), 40'h01_01_00_01_00);
    check40("model_s02", ribm(8'h02, 8'h02, 8'h02, 8'h02), 40'h08_08_00_10_00);
    check40("model_s80", ribm(8'h80, 8'h80, 8'h80, 8'h80), 40'h75_75_00_18_00);

    for (int i = 0; i < 3; i++) step();
    check40("reset_out", dut_out(), 40'h0);
    check1("reset_done", kif.kes_done, 1'b0);
    rstn = 1'b0;
    step();

    run_lit("zero", 8'h00, 40'h01_00_00_00_00);
    run_lit("ones", 8'h01, 40'h01_01_00_01_00);
    run_lit("twos", 8'h02, 40'h08_08_00_10_00);
    run_lit("x80",  8'h80, 40'h75_75_00_18_00);

    // Back-to-back: ena held high, a pulse every 5 cycles with identical results.
    kif.kes_ena = 1'b1;
    set_syn(8'h02, 8'h02, 8'h02, 8'h02);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (kif.kes_done === 1'b1) check40("b2b_out", dut_out(), 40'h08_08_00_10_00);
      check1("b2b_period", kif.kes_done, (i % 5) == 4);
    end
    tests++;
    if (ndone != 5) begin
      fails++;
      $display("FAIL b2b_count: got %0d expected 5", ndone);
    end
    kif.kes_ena = 1'b0;
    for (int i = 0; i < 2; i++) step();

    // Reset while in IT2 aborts the run and clears everything.
    kif.kes_ena = 1'b1;
    set_syn(8'h80, 8'h11, 8'h22, 8'h33);
    step();
    kif.kes_ena = 1'b0;
    rand_syn();
    step();
    step();
    rstn = 1'b1;
    step();
    check40("midrst_out", dut_out(), 40'h0);
    check1("midrst_done", kif.kes_done, 1'b0);
    rstn = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) step();
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL midrst_nopulse: got %0d pulses expected 0", ndone);
    end
    run_lit("after_rst", 8'h01, 40'h01_01_00_01_00);

    // Random traffic: random starts, syndromes toggling every cycle, rare resets.
    for (int i = 0; i < 400; i++) begin
      kif.kes_ena = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) set_syn(8'h00, 8'($urandom), 8'h00, 8'($urandom));
      else rand_syn();
      rstn = ($urandom_range(0, 79) == 0);
      step();
    end
    rstn = 1'b0;
    kif.kes_ena = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
